// File: rtl/sram_mp_init_if.sv
// Port bundle for the multi-port register-file SRAM: flattened read/write
// buses plus the clear/conflict status outputs.
interface sram_mp_init_if #(
    parameter int INDEX    = 4,
    parameter int WIDTH    = 8,
    parameter int RD_PORTS = 8,
    parameter int WR_PORTS = 16
);
    logic [RD_PORTS-1:0]       rd_en_i;
    logic [RD_PORTS*INDEX-1:0] rd_addr_i;
    logic [RD_PORTS*WIDTH-1:0] rd_data_o;
    logic [WR_PORTS-1:0]       wr_en_i;
    logic [WR_PORTS*INDEX-1:0] wr_addr_i;
    logic [WR_PORTS*WIDTH-1:0] wr_data_i;
    logic                      init_busy_o;
    logic                      wr_conflict_o;

    modport master (
        output rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        input  rd_data_o, init_busy_o, wr_conflict_o
    );

    modport slave (
        input  rd_en_i, rd_addr_i, wr_en_i, wr_addr_i, wr_data_i,
        output rd_data_o, init_busy_o, wr_conflict_o
    );
endinterface

// File: rtl/sram_mp_init.sv
// Parametrised multi-port register-file SRAM with sequenced post-reset clear,
// highest-port-wins write priority, optional write-to-read bypass and an
// optional registered read stage.
module sram_mp_init #(
    parameter int DEPTH      = 16,
    parameter int INDEX      = 4,
    parameter int WIDTH      = 8,
    parameter int RD_PORTS   = 8,
    parameter int WR_PORTS   = 16,
    parameter int RD_LATENCY = 0,
    parameter int BYPASS     = 1
) (
    input logic           clk,
    input logic           reset,
    sram_mp_init_if.slave bus
);
    typedef enum logic {S_INIT, S_READY} state_t;

    state_t                             state_q;
    logic [INDEX-1:0]                   cnt_q;
    logic                               busy_q;
    logic [WIDTH-1:0]                   mem_q [DEPTH];
    logic [WIDTH-1:0]                   mem_d [DEPTH];
    logic [RD_PORTS-1:0][WIDTH-1:0]     rd_comb;
    logic [RD_PORTS-1:0][WIDTH-1:0]     rd_q;
    logic [RD_PORTS-1:0][WIDTH-1:0]     rd_d;
    logic                               conflict_q;
    logic                               conflict_d;
    logic [DEPTH-1:0]                   hit;
    logic [DEPTH-1:0]                   multi;
    logic [DEPTH-1:0][WIDTH-1:0]        hit_data;
    logic                               ready;

    assign ready = (state_q == S_READY);

    // Per-entry winning write: scanning ports upward lets the highest index
    // overwrite; an entry hit twice marks a conflict. Out-of-range addresses
    // match no entry, so they are dropped and never flag a conflict.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            hit[e]      = 1'b0;
            multi[e]    = 1'b0;
            hit_data[e] = '0;
            for (int j = 0; j < WR_PORTS; j++) begin
                if (bus.wr_en_i[j] && bus.wr_addr_i[j*INDEX +: INDEX] == INDEX'(e)) begin
                    multi[e]    = multi[e] | hit[e];
                    hit[e]      = 1'b1;
                    hit_data[e] = bus.wr_data_i[j*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Next array contents: one entry cleared per cycle in INIT, winning writes in READY.
    always_comb begin
        for (int e = 0; e < DEPTH; e++) begin
            mem_d[e] = mem_q[e];
            if (!reset) begin
                if (!ready) begin
                    if (cnt_q == INDEX'(e)) mem_d[e] = '0;
                end else if (hit[e]) begin
                    mem_d[e] = hit_data[e];
                end
            end
        end
    end

    // Latency-0 read value per lane; zero while clearing or for out-of-range addresses.
    always_comb begin
        for (int k = 0; k < RD_PORTS; k++) begin
            rd_comb[k] = '0;
            for (int e = 0; e < DEPTH; e++) begin
                if (ready && bus.rd_addr_i[k*INDEX +: INDEX] == INDEX'(e))
                    rd_comb[k] = (BYPASS != 0 && hit[e]) ? hit_data[e] : mem_q[e];
            end
            rd_d[k] = bus.rd_en_i[k] ? rd_comb[k] : rd_q[k];
        end
        conflict_d = ready && (|multi);
    end

    // Clear sequencer: INIT walks the counter over every entry, then READY.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_INIT;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_INIT: begin
                    cnt_q <= cnt_q + INDEX'(1);
                    if (cnt_q == INDEX'(DEPTH - 1)) begin
                        state_q <= S_READY;
                        busy_q  <= 1'b0;
                    end
                end
                default: state_q <= S_READY;
            endcase
        end
    end

    // Array storage; contents before the clear finishes are never observable.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Registered read lanes and the one-cycle conflict pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_q       <= '0;
            conflict_q <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            conflict_q <= conflict_d;
        end
    end

    assign bus.rd_data_o     = (RD_LATENCY == 1) ? rd_q : rd_comb;
    assign bus.init_busy_o   = busy_q;
    assign bus.wr_conflict_o = conflict_q;
endmodule

// File: doc/sram_mp_init.md
# sram_mp_init

Parametrised multi-port register-file SRAM for the FabScalar physical register file, issue queue and rename tables. It generalises the fixed 8-read/16-write array to arbitrary port counts on flattened buses. It adds an optional registered read stage, deterministic write-conflict priority with a conflict flag, optional write-to-read bypass, and a sequenced clear after reset so that wide, deep arrays are not cleared in a single cycle.

## Interface
- DEPTH, 16, number of entries
- INDEX, 4, address width; DEPTH ≤ 2^INDEX
- WIDTH, 8, data width
- RD_PORTS, 8, number of read ports
- WR_PORTS, 16, number of write ports
- RD_LATENCY, 0, read latency: 0 = combinational, 1 = registered
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = read-before-write
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_en_i  in  RD_PORTS  read enables; used only when RD_LATENCY=1
- rd_addr_i  in  RD_PORTS*INDEX  read addresses; port k at bits [k*INDEX +: INDEX]
- rd_data_o  out  RD_PORTS*WIDTH  read data; port k at bits [k*WIDTH +: WIDTH]
- wr_en_i  in  WR_PORTS  write enables
- wr_addr_i  in  WR_PORTS*INDEX  write addresses
- wr_data_i  in  WR_PORTS*WIDTH  write data
- init_busy_o  out  1  array clear in progress
- wr_conflict_o  out  1  registered flag: two or more enabled write ports hit the same address

## Operation
- Reset and clear control is a two-state FSM: INIT and READY.
- Reset high:
  - FSM goes to INIT and the clear counter is set to 0.
  - init_busy_o=1, wr_conflict_o=0, rd_data_o registers cleared to 0.
- INIT, per clock edge with reset low:
  - Clear entry[counter] to 0 and increment the counter.
  - After the edge that clears entry DEPTH-1, go to READY and set init_busy_o=0.
- INIT behaviour:
  - All writes are dropped.
  - All rd_data_o lanes read 0, whatever BYPASS is set to.
  - wr_conflict_o stays 0.
- READY writes:
  - Each port with wr_en_i[j]=1 and wr_addr < DEPTH writes at the clock edge.
  - If several enabled ports target the same address, the highest port index wins.
  - Writes to addresses ≥ DEPTH are ignored.
- Read of an address ≥ DEPTH returns 0.
- BYPASS=1: a read address that matches the winning write this cycle returns the winning write data instead of the array contents.
- BYPASS=0: a read returns the pre-write array contents.
- RD_LATENCY=0: rd_data_o is a combinational function of rd_addr_i, the array and (with BYPASS=1) the write inputs.
- RD_LATENCY=1:
  - Lane k loads at the edge where rd_en_i[k]=1; it holds when rd_en_i[k]=0.
  - The loaded value is the value the latency-0 read would present in that cycle.
- wr_conflict_o: set at edge t+1 iff in cycle t (READY, reset low) at least two enabled ports targeted the same in-range address. Single-cycle pulse per conflicting cycle.

## Timing
- Clear duration: init_busy_o stays high for exactly DEPTH cycles after the first edge with reset low. The first write is accepted in the cycle after init_busy_o falls.
- Reset asserted mid-INIT or mid-READY: the FSM restarts INIT at counter 0 on the next edge.
- Array contents before the clear completes are unspecified, but never observable: reads return 0 during INIT.
- Write latency is 1 edge; a non-bypass read sees the new data in the cycle after the write.
- Latency-1 read: data is valid in the cycle after the rd_en_i edge.
- Read and write of the same address in the same cycle:
  - BYPASS=1: new data (latency 0: same cycle; latency 1: next cycle).
  - BYPASS=0: old data.
- No back-pressure and no handshake. Every enabled port is serviced every READY cycle.

## Test plan
- Reset clear (DEPTH=16): hold reset 3 cycles, then release → init_busy_o=1 for exactly 16 cycles; writes issued during that window are dropped; afterwards all 16 entries read 0x00.
- Reset mid-INIT: reassert reset after 5 clear cycles, release again → init_busy_o=1 for a fresh 16 cycles.
- Write priority: in READY, ports 2, 7 and 15 write 0x11, 0x22 and 0x33 to addr 5 → entry 5 = 0x33; wr_conflict_o=1 for exactly one cycle, 1 cycle later.
- Bypass, RD_LATENCY=0, BYPASS=1: entry 3 = 0xAA, write 0x5C to addr 3 while reading addr 3 → rd_data_o lane shows 0x5C the same cycle. With BYPASS=0 → 0xAA, then 0x5C the next cycle.
- Registered read, RD_LATENCY=1: set rd_en_i[4]=1 on addr 9 (= 0x7E) for one cycle, then deassert → lane 4 = 0x7E from the next cycle; it holds while addr 9 is rewritten to 0x01.
- Out of range, DEPTH=12: write 0xFF to addr 13 → no entry changes; a read of addr 13 returns 0x00; no conflict flagged.
